// File: rtl/seq_subtractor_if.sv
// Operand/result handshake bundle for seq_subtractor.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready.
interface seq_subtractor_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             abs_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             neg;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, abs_mode, out_ready,
        input  in_ready, out_valid, diff, borrow_out, neg, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bin, abs_mode, out_ready,
        output in_ready, out_valid, diff, borrow_out, neg, ovf, zero
    );
endinterface

// File: rtl/seq_subtractor.sv
// Slice-serial subtractor: A - B - bin, SLICE bits per clock with a registered borrow,
// plus an optional negate pass that turns a borrowing result into unsigned |A - B|.
module seq_subtractor #(
    parameter int WIDTH = 32,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    seq_subtractor_if.slave  bus,
    output logic [1:0]       dbg_state_o
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    generate
        if ((SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_bad_param
            $error("seq_subtractor: WIDTH must be a multiple of SLICE and SLICE <= WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;

    state_t           state_q;
    logic [IDXW-1:0]  idx_q;
    logic             brw_q;
    logic             abs_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] d_q;
    logic             out_valid_q;
    logic             borrow_out_q;
    logic             neg_q;
    logic             ovf_q;
    logic             zero_q;

    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic [SLICE-1:0] sl_d;
    logic             brw_d;
    logic [WIDTH-1:0] d_d;
    int               lo;

    // The negate pass reuses the same slice subtractor with a forced-zero minuend.
    always_comb begin
        lo = int'(idx_q) * SLICE;
        if (state_q == NEG) begin
            sl_a = '0;
            sl_b = d_q[lo +: SLICE];
        end else begin
            sl_a = a_q[lo +: SLICE];
            sl_b = b_q[lo +: SLICE];
        end
        {brw_d, sl_d} = {1'b0, sl_a} - {1'b0, sl_b} - {{SLICE{1'b0}}, brw_q};
        d_d = d_q;
        d_d[lo +: SLICE] = sl_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            brw_q        <= 1'b0;
            abs_q        <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            d_q          <= '0;
            out_valid_q  <= 1'b0;
            borrow_out_q <= 1'b0;
            neg_q        <= 1'b0;
            ovf_q        <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        abs_q   <= bus.abs_mode;
                        brw_q   <= bus.bin & ~bus.abs_mode;
                        idx_q   <= '0;
                        state_q <= SUB;
                    end
                end
                SUB: begin
                    d_q   <= d_d;
                    brw_q <= brw_d;
                    idx_q <= idx_q + IDXW'(1);
                    if (idx_q == LAST_IDX) begin
                        idx_q        <= '0;
                        borrow_out_q <= brw_d;
                        neg_q        <= d_d[WIDTH-1];
                        ovf_q        <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_d[WIDTH-1] != a_q[WIDTH-1]);
                        if (abs_q && brw_d) begin
                            brw_q   <= 1'b0;
                            state_q <= NEG;
                        end else begin
                            zero_q      <= (d_d == '0);
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                NEG: begin
                    d_q   <= d_d;
                    brw_q <= brw_d;
                    idx_q <= idx_q + IDXW'(1);
                    if (idx_q == LAST_IDX) begin
                        idx_q       <= '0;
                        zero_q      <= (d_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state_q == IDLE) && !rst;
    assign bus.out_valid  = out_valid_q;
    assign bus.diff       = d_q;
    assign bus.borrow_out = borrow_out_q;
    assign bus.neg        = neg_q;
    assign bus.ovf        = ovf_q;
    assign bus.zero       = zero_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_seq_subtractor.sv
// Bench for seq_subtractor: directed W32/S16 vectors plus random W24/S8 ops,
// all results scored against an arithmetic model of A-B-bin and |A-B|.
module tb_seq_subtractor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_subtractor_if #(.WIDTH(32)) if32 ();
  seq_subtractor_if #(.WIDTH(24)) if24 ();
  logic [1:0] st32, st24;

  seq_subtractor #(.WIDTH(32), .SLICE(16)) dut32 (
    .clk(clk), .rst(rst), .bus(if32.slave), .dbg_state_o(st32)
  );
  seq_subtractor #(.WIDTH(24), .SLICE(8)) dut24 (
    .clk(clk), .rst(rst), .bus(if24.slave), .dbg_state_o(st24)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [35:0] exp32_q[$];
  logic [35:0] exp24_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Result packed as {diff[31:0], borrow_out, neg, ovf, zero}.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic bin, input logic abs_m, input int w);
    longint m, ua, ub, bi, half, sa, sb, s, d;
    logic brw, ng, ov;
    m    = (longint'(1) <<< w) - 1;
    half = longint'(1) <<< (w - 1);
    ua   = longint'({32'd0, a}) & m;
    ub   = longint'({32'd0, b}) & m;
    bi   = (bin && !abs_m) ? 1 : 0;
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    s    = sa - sb - bi;
    brw  = (ua < ub + bi);
    d    = (ua - ub - bi) & m;
    ng   = (d >= half);
    ov   = (s < -half) || (s >= half);
    if (abs_m && brw) d = ub - ua;
    return {d[31:0], brw, ng, ov, d == 0};
  endfunction

  // Scoreboard: capture on accept, compare every cycle a result is presented.
  always @(negedge clk) begin
    if (rst) begin
      exp32_q.delete();
      exp24_q.delete();
    end else begin
      if (if32.in_valid && if32.in_ready)
        exp32_q.push_back(model(if32.a, if32.b, if32.bin, if32.abs_mode, 32));
      if (if24.in_valid && if24.in_ready)
        exp24_q.push_back(model({8'd0, if24.a}, {8'd0, if24.b}, if24.bin, if24.abs_mode, 24));
      if (if32.out_valid) begin
        if (exp32_q.size() == 0) chk("dut32 unexpected result", exp32_q.size(), 1);
        else begin
          chk("dut32 result", {if32.diff, if32.borrow_out, if32.neg, if32.ovf, if32.zero}, exp32_q[0]);
          if (if32.out_ready) void'(exp32_q.pop_front());
        end
      end
      if (if24.out_valid) begin
        if (exp24_q.size() == 0) chk("dut24 unexpected result", exp24_q.size(), 1);
        else begin
          chk("dut24 result", {8'd0, if24.diff, if24.borrow_out, if24.neg, if24.ovf, if24.zero}, exp24_q[0]);
          if (if24.out_ready) void'(exp24_q.pop_front());
        end
      end
    end
  end

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic bin, input logic abs_m,
                      input logic [31:0] ediff, input logic [3:0] eflags, input int elat, input string name);
    int n;
    n = 0;
    while (!if32.in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk({name, " in_ready"}, if32.in_ready, 1);
    if32.a = a; if32.b = b; if32.bin = bin; if32.abs_mode = abs_m;
    if32.in_valid = 1'b1; if32.out_ready = 1'b1;
    @(posedge clk); #1;
    if32.in_valid = 1'b0;
    n = 0;
    while (!if32.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk({name, " latency"}, n, elat);
    chk({name, " diff"}, if32.diff, ediff);
    chk({name, " flags"}, {if32.borrow_out, if32.neg, if32.ovf, if32.zero}, eflags);
    @(posedge clk); #1;
  endtask

  task automatic rand_op24(input int k);
    int n;
    logic [23:0] a, b;
    logic bin, abs_m, r;
    n = 0;
    while (!if24.in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("dut24 in_ready", if24.in_ready, 1);
    case (k % 4)
      0: begin a = 24'($urandom); b = 24'($urandom); end
      1: begin a = 24'($urandom_range(0, 15)); b = 24'($urandom_range(0, 15)); end
      2: begin a = 24'($urandom); b = a; end
      default: begin a = {1'b1, 23'($urandom)}; b = {1'b0, 23'($urandom)}; end
    endcase
    bin = 1'($urandom_range(0, 1));
    abs_m = 1'($urandom_range(0, 1));
    if24.a = a; if24.b = b; if24.bin = bin; if24.abs_mode = abs_m;
    if24.in_valid = 1'b1; if24.out_ready = 1'b0;
    @(posedge clk); #1;
    if24.in_valid = 1'b0;
    n = 0;
    while (!if24.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("dut24 latency", n, (abs_m && (a < b)) ? 6 : 3);
    n = 0;
    do begin
      r = 1'($urandom_range(0, 1));
      if24.out_ready = r;
      @(posedge clk); #1;
      n++;
    end while (!r && n < 50);
    if24.out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    if32.in_valid = 0; if32.a = 0; if32.b = 0; if32.bin = 0; if32.abs_mode = 0; if32.out_ready = 0;
    if24.in_valid = 0; if24.a = 0; if24.b = 0; if24.bin = 0; if24.abs_mode = 0; if24.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", if32.out_valid, 0);
    chk("reset diff", if32.diff, 0);
    chk("reset flags", {if32.borrow_out, if32.neg, if32.ovf, if32.zero}, 0);
    chk("reset in_ready", if32.in_ready, 0);
    rst = 1'b0;
    #1;
    chk("in_ready after release", if32.in_ready, 1);
    @(posedge clk); #1;

    chk("model pin 5-7", model(5, 7, 0, 0, 32), {32'hFFFF_FFFE, 4'b1100});
    chk("model pin abs 5-7", model(5, 7, 0, 1, 32), {32'h0000_0002, 4'b1100});
    chk("model pin w24 0-1", model(0, 1, 0, 0, 24), {32'h00FF_FFFF, 4'b1100});
    chk("model pin w24 ovf", model(32'h0080_0000, 1, 0, 0, 24), {32'h007F_FFFF, 4'b0010});

    op32(32'h0001_0000, 1, 0, 0, 32'h0000_FFFF, 4'b0000, 2, "cross-slice");
    op32(5, 7, 0, 0, 32'hFFFF_FFFE, 4'b1100, 2, "5-7");
    op32(5, 7, 0, 1, 32'h0000_0002, 4'b1100, 4, "abs 5-7");
    op32(7, 5, 0, 1, 32'h0000_0002, 4'b0000, 2, "abs 7-5");
    op32(5, 5, 1, 1, 32'h0000_0000, 4'b0001, 2, "abs ignores bin");
    op32(32'h8000_0000, 1, 0, 0, 32'h7FFF_FFFF, 4'b0010, 2, "signed ovf");
    op32(32'h1234, 32'h1234, 0, 0, 32'h0000_0000, 4'b0001, 2, "equal zero");
    op32(0, 0, 1, 0, 32'hFFFF_FFFF, 4'b1100, 2, "wrap bin");

    // Stalled result with fresh operands offered; nothing may be captured.
    if32.a = 10; if32.b = 3; if32.bin = 0; if32.abs_mode = 0;
    if32.in_valid = 1'b1; if32.out_ready = 1'b0;
    @(posedge clk); #1;
    if32.in_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!if32.out_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk("stall latency", n, 2);
    end
    if32.a = 32'hDEAD_BEEF; if32.b = 1; if32.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall diff", if32.diff, 7);
      chk("stall in_ready", if32.in_ready, 0);
      chk("stall out_valid", if32.out_valid, 1);
      @(posedge clk); #1;
    end
    if32.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release out_valid", if32.out_valid, 0);
    chk("release in_ready", if32.in_ready, 1);
    if32.in_valid = 1'b0;
    @(posedge clk); #1;
    op32(100, 1, 1, 0, 32'd98, 4'b0000, 2, "after stall");

    // Reset during the second SUB cycle aborts the operation.
    if32.a = 32'h0001_0000; if32.b = 1; if32.bin = 0; if32.abs_mode = 0;
    if32.in_valid = 1'b1; if32.out_ready = 1'b1;
    @(posedge clk); #1;
    if32.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midreset out_valid", if32.out_valid, 0);
    chk("midreset diff", if32.diff, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midreset no result", if32.out_valid, 0);
    chk("midreset in_ready", if32.in_ready, 1);
    op32(32'h0001_0000, 1, 0, 0, 32'h0000_FFFF, 4'b0000, 2, "after reset");

    for (int k = 0; k < 1000; k++) rand_op24(k);

    @(posedge clk); #1;
    chk("dut32 queue drained", exp32_q.size(), 0);
    chk("dut24 queue drained", exp24_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
